// File: rtl/counter.sv
// counter: WIDTH-bit up-counter. It advances by one on a rising clk edge only
// when count_en and count_valid are both high, and it wraps silently from the
// all-ones value to zero. resetn is an asynchronous reset that is active-high
// despite its name. While resetn is high the count is forced to RESET_VAL.
module counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             count_en,
  input  logic             count_valid,
  output logic [WIDTH-1:0] o_count
);

  // RESET_VAL is truncated to the counter width. The caller must keep it in range.
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             count_qual;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // The two qualifiers have equal weight: both must be high at the edge.
  assign count_qual = count_en & count_valid;

  // Next-count logic. The default is to hold. A qualified edge adds one and
  // relies on modular wrap, so there is no saturation and no flag.
  always_comb begin
    count_d = count_q;
    if (count_qual) begin
      count_d = count_q + ONE;
    end
  end

  // Count register. Reset is asynchronous, so it does not wait for a clock edge.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      count_q <= RST_V;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: runs directed sequences and randomized stimulus against two
// counter instances, one with the default width 8 and reset 0, and one with
// width 4 and reset 3. The expected count comes from the number of qualified
// edges since the last reset: (RESET_VAL + n) mod 2^WIDTH.
module tb_counter;

  logic       clk;
  logic       resetn;
  logic       count_en;
  logic       count_valid;
  logic [7:0] o_count8;
  logic [3:0] o_count4;

  int total;
  int bad;
  int n_qual;   // qualified edges since the last reset

  counter #(.WIDTH(8), .RESET_VAL(0)) dut8 (
    .clk         (clk),
    .resetn      (resetn),
    .count_en    (count_en),
    .count_valid (count_valid),
    .o_count     (o_count8)
  );

  counter #(.WIDTH(4), .RESET_VAL(3)) dut4 (
    .clk         (clk),
    .resetn      (resetn),
    .count_en    (count_en),
    .count_valid (count_valid),
    .o_count     (o_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. It counts the check and reports any mismatch.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp8();
    return 32'((0 + n_qual) % 256);
  endfunction

  function automatic logic [31:0] exp4();
    return 32'((3 + n_qual) % 16);
  endfunction

  // One clock cycle. When glitch is set, the inputs are driven to the opposite
  // values early in the cycle and then restored before the edge. The outputs
  // of both DUTs are checked 1 ns after the edge.
  task automatic tick(input logic en, input logic val, input logic rst, input logic glitch, input string tag);
    if (glitch) begin
      count_en    = ~en;
      count_valid = ~val;
      #2;
    end
    count_en    = en;
    count_valid = val;
    resetn      = rst;
    @(posedge clk);
    #1;
    if (rst) n_qual = 0;
    else if (en && val) n_qual++;
    check_val({tag, "_w8"}, 32'(o_count8), exp8());
    check_val({tag, "_w4"}, 32'(o_count4), exp4());
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, "rst");
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    n_qual      = 0;
    resetn      = 1'b1;
    count_en    = 1'b1;
    count_valid = 1'b1;
    #1;
    check_val("reset_t0_w8", 32'(o_count8), 32'd0);
    check_val("reset_t0_w4", 32'(o_count4), 32'd3);

    // Hold reset for 10 cycles with both qualifiers high. The count must stay at RESET_VAL.
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, "reset_hold");
      check_val("reset_hold_const", 32'(o_count8), 32'd0);
    end
    // After release, successive edges produce 1, 2, 3 (and 4, 5, 6 at width 4).
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, "release");
      check_val("release_const_w8", 32'(o_count8), 32'(i));
      check_val("release_const_w4", 32'(o_count4), 32'(3 + i));
    end

    // Qualifier, hold and resume sequence.
    do_reset();
    for (int i = 0; i < 50; i++)  tick(1'b1, 1'b0, 1'b0, 1'b0, "valid_low");
    check_val("valid_low_const", 32'(o_count8), 32'd0);
    for (int i = 0; i < 20; i++)  tick(1'b1, 1'b1, 1'b0, 1'b0, "count20");
    check_val("count20_const", 32'(o_count8), 32'h14);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, "en_low");
    check_val("en_low_const", 32'(o_count8), 32'h14);
    for (int i = 0; i < 50; i++)  tick(1'b1, 1'b0, 1'b0, 1'b0, "valid_low2");
    check_val("valid_low2_const", 32'(o_count8), 32'h14);
    for (int i = 0; i < 10; i++)  tick(1'b1, 1'b1, 1'b0, 1'b0, "resume");
    check_val("resume_const", 32'(o_count8), 32'h1E);

    // Wrap sequence: 8-bit wraps at edge 256. The 4-bit instance goes 3 to 15 to 0.
    do_reset();
    for (int i = 1; i <= 257; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, "wrap");
      if (i == 12)  check_val("w4_at15", 32'(o_count4), 32'd15);
      if (i == 13)  check_val("w4_wrap0", 32'(o_count4), 32'd0);
      if (i == 255) check_val("wrap_ff", 32'(o_count8), 32'hFF);
      if (i == 256) check_val("wrap_00", 32'(o_count8), 32'h00);
      if (i == 257) check_val("wrap_01", 32'(o_count8), 32'h01);
    end

    // Asynchronous reset pulse in mid-cycle at count 0x80.
    do_reset();
    for (int i = 0; i < 128; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, "to80");
    check_val("at80", 32'(o_count8), 32'h80);
    #2;
    resetn = 1'b1;
    #1;
    check_val("async_rst_w8", 32'(o_count8), 32'd0);
    check_val("async_rst_w4", 32'(o_count4), 32'd3);
    resetn = 1'b0;
    n_qual = 0;
    tick(1'b1, 1'b1, 1'b0, 1'b0, "after_pulse");
    check_val("after_pulse_const", 32'(o_count8), 32'd1);

    // Randomized stimulus with mid-cycle glitches and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic r_en;
      logic r_val;
      logic r_rst;
      logic r_gl;
      r_en  = 1'($urandom_range(0, 3) != 0);
      r_val = 1'($urandom_range(0, 3) != 0);
      r_rst = 1'($urandom_range(0, 99) == 0);
      r_gl  = 1'($urandom_range(0, 1));
      tick(r_en, r_val, r_rst, r_gl, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
